// File: rtl/control_mac.sv
// control_mac: sequences TAPS sample/coefficient pairs through one signed multiplier
// and accumulates the products into a wide accumulator. When the run is complete it
// drops the low F fraction bits (floor) and saturates the sum back to Q(M.F).
// Ports: clk, rst_n (async, active low); inicio starts a result.
// muestra/coef are the combinational read data at dir.
// ocupado is high while a result is in progress.
// salida/saturado hold the last result, and valido pulses when they update.
module control_mac #(
   parameter int N    = 16,
   parameter int M    = 7,
   parameter int F    = 8,
   parameter int TAPS = 8,
   parameter int AW   = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inicio,
   input  logic [N-1:0]  muestra,
   input  logic [N-1:0]  coef,
   output logic [AW-1:0] dir,
   output logic          ocupado,
   output logic [N-1:0]  salida,
   output logic          valido,
   output logic          saturado
);
   localparam int AccW = 2*N+AW;
   typedef enum logic [1:0] {REPOSO, LECTURA, SALIDA} estado_t;
   estado_t             estado_q, estado_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic [AccW-1:0]     acc_q, acc_d;
   logic [N-1:0]        salida_q, salida_d;
   logic                valido_q, valido_d;
   logic                saturado_q, saturado_d;
   logic signed [2*N-1:0] prod;
   logic [AccW-1:M+2*F] alto;
   logic                fuera;
   assign prod     = $signed(muestra) * $signed(coef);
   // the result fits only if every bit from the result sign bit upward is identical
   assign alto     = acc_q[AccW-1:M+2*F];
   assign fuera    = !(&alto || ~|alto);
   assign dir      = estado_q == LECTURA ? idx_q : '0;
   assign ocupado  = estado_q != REPOSO;
   assign salida   = salida_q;
   assign valido   = valido_q;
   assign saturado = saturado_q;
   always_comb begin
      estado_d   = estado_q;
      idx_d      = idx_q;
      acc_d      = acc_q;
      salida_d   = salida_q;
      saturado_d = saturado_q;
      valido_d   = 1'b0;
      case (estado_q)
         REPOSO: begin
            if (inicio) begin
               estado_d = LECTURA;
               idx_d    = '0;
               acc_d    = '0;
            end
         end
         LECTURA: begin
            acc_d    = acc_q + {{AW{prod[2*N-1]}}, prod};
            idx_d    = idx_q + AW'(1);
            estado_d = idx_q == AW'(TAPS-1) ? SALIDA : LECTURA;
         end
         SALIDA: begin
            estado_d   = REPOSO;
            valido_d   = 1'b1;
            saturado_d = fuera;
            salida_d   = !fuera ? acc_q[N+F-1:F] :
                         acc_q[AccW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
         end
         default: estado_d = REPOSO;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q   <= REPOSO;
         idx_q      <= '0;
         acc_q      <= '0;
         salida_q   <= '0;
         valido_q   <= 1'b0;
         saturado_q <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         idx_q      <= idx_d;
         acc_q      <= acc_d;
         salida_q   <= salida_d;
         valido_q   <= valido_d;
         saturado_q <= saturado_d;
      end
   end
endmodule

// File: tb/tb_control_mac.sv
// tb_control_mac: directed and randomized checks of control_mac against an arithmetic reference model
module tb_control_mac;
   localparam int N = 16, M = 7, F = 8, TAPS = 8, AW = 3;
   logic          clk = 1'b0;
   logic          rst_n;
   logic          inicio;
   logic [N-1:0]  muestra, coef;
   logic [AW-1:0] dir;
   logic          ocupado, valido, saturado;
   logic [N-1:0]  salida;
   logic [N-1:0]  ms [TAPS];
   logic [N-1:0]  mc [TAPS];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   control_mac #(.N(N), .M(M), .F(F), .TAPS(TAPS), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .inicio(inicio), .muestra(muestra), .coef(coef),
      .dir(dir), .ocupado(ocupado), .salida(salida), .valido(valido), .saturado(saturado)
   );
   assign muestra = ms[dir];
   assign coef    = mc[dir];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // exact sum of real products, floored to F fraction bits, then clamped to the N-bit range
   function automatic logic [N:0] model();
      longint sum = 0;
      longint q;
      for (int i = 0; i < TAPS; i++)
         sum += longint'($signed(ms[i])) * longint'($signed(mc[i]));
      q = sum >>> F;
      if (q > 32767) return {1'b1, 16'h7fff};
      if (q < -32768) return {1'b1, 16'h8000};
      return {1'b0, 16'(q)};
   endfunction
   task automatic fill(input logic [N-1:0] s, input logic [N-1:0] c);
      for (int i = 0; i < TAPS; i++) begin
         ms[i] = s;
         mc[i] = c;
      end
   endtask
   task automatic run(input string tag, input bit repulse);
      logic [N:0] e;
      int n_ocu;
      bit got;
      e = model();
      n_ocu = 0;
      got = 0;
      @(negedge clk) inicio = 1'b1;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         inicio = repulse && (c == 1 || c == 4);
         if (valido) begin
            got = 1;
            chk({tag, " salida"}, 32'(salida), 32'(e[N-1:0]));
            chk({tag, " saturado"}, 32'(saturado), 32'(e[N]));
            chk({tag, " ocupado_cycles"}, 32'(n_ocu), TAPS + 1);
            chk({tag, " ocupado_at_valido"}, 32'(ocupado), 0);
         end else if (ocupado) begin
            chk({tag, " dir"}, 32'(dir), n_ocu < TAPS ? 32'(n_ocu) : 0);
            n_ocu++;
         end
      end
      chk({tag, " valido_seen"}, 32'(got), 1);
      @(negedge clk);
      chk({tag, " valido_one_cycle"}, 32'(valido), 0);
   endtask
   task automatic wait_valido(output bit ok);
      ok = 0;
      for (int c = 0; c < 30 && !ok; c++) begin
         @(negedge clk);
         ok = valido;
      end
   endtask
   initial begin
      logic [N:0] e;
      bit ok, seen;
      int t0;
      rst_n  = 1'b0;
      inicio = 1'b0;
      fill(16'h0000, 16'h0000);
      repeat (2) @(negedge clk);
      chk("reset dir", 32'(dir), 0);
      chk("reset ocupado", 32'(ocupado), 0);
      chk("reset salida", 32'(salida), 0);
      chk("reset valido", 32'(valido), 0);
      chk("reset saturado", 32'(saturado), 0);
      rst_n = 1'b1;
      @(negedge clk);
      fill(16'h0100, 16'h0100);
      run("unit", 0);
      chk("unit literal", 32'(salida), 32'h0800);
      fill(16'h7fff, 16'h7fff); run("sat_pos", 0);
      fill(16'h8000, 16'h7fff); run("sat_neg", 0);
      fill(16'hff80, 16'h0100); run("trunc_half", 0);
      fill(16'h0001, 16'h0001); run("trunc_tiny", 0);
      fill(16'hffff, 16'h0001); run("trunc_floor", 0);
      for (int i = 0; i < TAPS; i++) begin
         ms[i] = i % 2 == 0 ? 16'h0100 : 16'hff00;
         mc[i] = 16'h0200;
      end
      run("mixed_zero", 0);
      ms[0] = 16'h0180; run("mixed_pos", 0);
      ms[0] = 16'h0100; ms[1] = 16'hfe80; run("mixed_neg", 0);
      fill(16'h0100, 16'h0100);
      run("repulse", 1);
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < TAPS; i++) begin
            ms[i] = r < 3 ? 16'($urandom) : 16'($urandom_range(0, 2047) - 1024);
            mc[i] = r < 3 ? 16'($urandom) : 16'($urandom_range(0, 2047) - 1024);
         end
         run($sformatf("rand%0d", r), 0);
      end
      e = model();
      inicio = 1'b1;
      wait_valido(ok);
      chk("held first valido", 32'(ok), 1);
      chk("held first salida", 32'(salida), 32'(e[N-1:0]));
      t0 = cyc;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         wait_valido(ok);
         chk("held valido", 32'(ok), 1);
         chk("held period", 32'(cyc - t0), 10);
         chk("held salida", 32'(salida), 32'(e[N-1:0]));
         t0 = cyc;
      end
      inicio = 1'b0;
      @(negedge clk);
      chk("held release ocupado", 32'(ocupado), 0);
      fill(16'h0100, 16'h0100);
      @(negedge clk) inicio = 1'b1;
      @(negedge clk) inicio = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst mid dir", 32'(dir), 3);
      rst_n = 1'b0;
      #1;
      chk("rst mid dir0", 32'(dir), 0);
      chk("rst mid ocupado", 32'(ocupado), 0);
      chk("rst mid salida", 32'(salida), 0);
      chk("rst mid valido", 32'(valido), 0);
      chk("rst mid saturado", 32'(saturado), 0);
      @(negedge clk) rst_n = 1'b1;
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         seen = seen | valido | ocupado;
      end
      chk("rst no valido", 32'(seen), 0);
      run("after_rst", 0);
      chk("after_rst literal", 32'(salida), 32'h0800);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/control_mac.md
Name: control_mac

Overview:
- Sequencer for the shared fixed-point multiply-accumulate datapath.
- On `inicio`, walks TAPS sample/coefficient pairs through one signed N x N multiplier and accumulates them in the widened 2N-bit Q format, 2F fraction bits.
- Truncates and saturates the sum back to the N-bit Q(M.F) format and pulses `valido`.
- Sits between the sample/coefficient register files and the filter output register.

Parameters:
N, 16, total word width; N = 1 + M + F
M, 7, integer bits (excluding sign)
F, 8, fraction bits
TAPS, 8, products per result (>=2)
AW, 3, address width; 2^AW >= TAPS

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
inicio  in  1  start request, sampled only in REPOSO
muestra  in  N  signed sample at `dir`; combinational read, valid in the same cycle as `dir`
coef  in  N  signed coefficient at `dir`; same timing as `muestra`
dir  out  AW  read address for sample/coef files
ocupado  out  1  high while a result is in progress
salida  out  N  signed Q(M.F) result, held until next result
valido  out  1  one-cycle pulse: `salida` updated
saturado  out  1  high with `salida` if last result clipped; held until next result

Behaviour:
- Reset (async, rst_n=0): state REPOSO; dir=0, ocupado=0, salida=0, valido=0, saturado=0; accumulator=0, index=0. Asserting reset mid-computation discards the partial result; no `valido` follows.
- States:
  - REPOSO: ocupado=0. inicio=1 at edge E0 → LECTURA; idx=0, acc=0.
  - LECTURA: ocupado=1, dir=idx. At each edge: acc += sign-extended(muestra*coef); idx++. When idx==TAPS-1 at the edge → SALIDA. Total TAPS LECTURA cycles, accumulating at edges E1..E_TAPS.
  - SALIDA: ocupado=1. At edge E_TAPS+1: register salida and saturado, valido=1 → REPOSO.
- valido is high for exactly one cycle after E_TAPS+1, during REPOSO.
- Arithmetic:
  - product = signed N x N → 2N bits, 2F fraction bits.
  - acc width = 2N+AW; each product is sign-extended into it, so the accumulator never wraps.
  - Result = acc[N+F-1:F]; low F bits are truncated toward −inf (floor, no rounding).
  - Saturation: if acc[2N+AW-1:N+F-1] are not all equal, clip. Positive clips to {0, all ones} = 0x7FFF at N=16; negative clips to {1, all zeros} = 0x8000. In both cases saturado=1, otherwise saturado=0.
- inicio while ocupado=1: ignored, no queueing.
- inicio in the cycle valido=1 (REPOSO): accepted; back-to-back results every TAPS+2 cycles.
- dir holds 0 in REPOSO. Inputs are sampled only in LECTURA.

Test Plan:
- Defaults; all muestra=0x0100, coef=0x0100 (1.0); pulse inicio → dir steps 0..7 on consecutive cycles; valido one cycle after E9; salida=0x0800 (8.0); saturado=0; ocupado high exactly 9 cycles.
- All muestra=0x7FFF, coef=0x7FFF → salida=0x7FFF, saturado=1. All muestra=0x8000, coef=0x7FFF → salida=0x8000, saturado=1.
- Truncation:
  - muestra=0xFF80 (−0.5), coef=0x0100 → salida=0xFC00.
  - muestra=0x0001, coef=0x0001 → salida=0x0000.
  - muestra=0xFFFF, coef=0x0001 → salida=0xFFFF (floor).
  - All three with saturado=0.
- Mixed signs: taps alternate +1.0/−1.0 samples, coef=0x0200 → salida=0x0000. Then one tap changed to 0x0180 → salida=0xFF00 or 0x0100 per tap sign; check against golden model.
- Control:
  - inicio re-pulsed at cycles 2 and 5 of a run → no effect on dir sequence or result.
  - inicio held high → back-to-back results, valido every 10 cycles.
- Reset: drop rst_n for 1 cycle after 3 taps (asynchronously, mid-cycle) → all outputs 0 immediately; no valido; subsequent inicio yields a correct 0x0800 result.
